// File: rtl/spi_regbank_pkg.sv
// Shared types and constants for the SPI register bank.
package spi_regbank_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } spi_state_e;

    localparam int CMD_W  = 8;
    localparam int RD_BIT = 7;
    localparam int ADDR_W = CMD_W - 1;

    // Highest decoded address; the burst address wraps to 0 after it.
    function automatic int addr_last(input int num_cfg, input int num_stat);
        return num_cfg + num_stat - 1;
    endfunction

endpackage

// File: rtl/spi_regbank_if.sv
// SPI pin bundle between the chip pads (master side) and the register bank (slave side).
interface spi_regbank_if;

    logic spi_cs_n;
    logic spi_clk;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_cs_n,
        output spi_clk,
        output spi_mosi,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_cs_n,
        input  spi_clk,
        input  spi_mosi,
        output spi_miso,
        output spi_miso_oe
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with single-clk rise/fall pulses.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    // [0] may be metastable, [1] is the synchronised level, [2] is its previous value
    logic [2:0] sync_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], d};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_regbank.sv
// SPI mode-0 slave with a parametrised RW config bank and snapshotted RO status bank.
// Optional interrupt on rising status bits when SPI_REGBANK_IRQ_EN is defined.
module spi_regbank
    import spi_regbank_pkg::*;
#(
    parameter int               NUM_CFG     = 8,
    parameter int               NUM_STAT    = 4,
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] CFG_RST_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    spi_regbank_if.slave              spi,
    output logic [NUM_CFG*WIDTH-1:0]  config_regs,
    output logic [NUM_CFG-1:0]        cfg_wr_pulse,
    input  logic [NUM_STAT*WIDTH-1:0] status_regs
`ifdef SPI_REGBANK_IRQ_EN
    ,
    output logic                      irq
`endif
);

    localparam int               SHADOW_N  = (NUM_STAT > 0) ? NUM_STAT : 1;
    localparam int               CNT_W     = 6;
    localparam int               ADDR_LAST = addr_last(NUM_CFG, NUM_STAT);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WIDTH - 1);

    logic              sclk_rise;
    logic              sclk_fall;
    logic              cs_rise;
    logic              cs_fall;
    logic [1:0]        mosi_sync;
    logic              mosi_q;

    spi_state_e        state;
    spi_state_e        state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WIDTH-2:0]  shift_in;
    logic [ADDR_W-1:0] addr;
    logic              rd_frame;
    logic [WIDTH-1:0]  tx_sh;
    logic [WIDTH-1:0]  rd_value;
    logic [WIDTH-1:0]  shadow [SHADOW_N];
    logic [WIDTH-1:0]  cfg_q [NUM_CFG];
    logic              miso_oe;

    logic              commit_pend;
    logic              commit_rd;
    logic [ADDR_W-1:0] commit_addr;
    logic [WIDTH-1:0]  commit_data;

    spi_sync_edge u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (spi.spi_clk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (spi.spi_cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // Same depth as the sclk synchroniser, so mosi_q is aligned with sclk_rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_sync <= '0;
        end else begin
            mosi_sync <= {mosi_sync[0], spi.spi_mosi};
        end
    end

    assign mosi_q = mosi_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = CMD;
            CMD:     if (sclk_rise && bit_cnt == CMD_LAST) state_nxt = DATA;
            default: state_nxt = state;
        endcase
        if (cs_rise) state_nxt = IDLE;
    end

    always_comb begin
        rd_value = '0;
        for (int k = 0; k < NUM_CFG; k++) begin
            if (int'(addr) == k) rd_value = cfg_q[k];
        end
        for (int s = 0; s < NUM_STAT; s++) begin
            if (int'(addr) == NUM_CFG + s) rd_value = shadow[s];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            shift_in    <= '0;
            addr        <= '0;
            rd_frame    <= 1'b0;
            tx_sh       <= '0;
            commit_pend <= 1'b0;
            commit_rd   <= 1'b0;
            commit_addr <= '0;
            commit_data <= '0;
            for (int s = 0; s < SHADOW_N; s++) shadow[s] <= '0;
        end else begin
            commit_pend <= 1'b0;
            if (cs_rise) begin
                bit_cnt <= '0;
            end else begin
                case (state)
                    CMD: begin
                        if (sclk_rise) begin
                            shift_in <= {shift_in[WIDTH-3:0], mosi_q};
                            if (bit_cnt == CMD_LAST) begin
                                bit_cnt  <= '0;
                                rd_frame <= shift_in[RD_BIT-1];
                                addr     <= {shift_in[ADDR_W-2:0], mosi_q};
                                tx_sh    <= '0;
                                for (int s = 0; s < NUM_STAT; s++) begin
                                    shadow[s] <= status_regs[s*WIDTH +: WIDTH];
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        if (sclk_rise) begin
                            shift_in <= {shift_in[WIDTH-3:0], mosi_q};
                            if (bit_cnt == WORD_LAST) begin
                                bit_cnt     <= '0;
                                commit_pend <= 1'b1;
                                commit_rd   <= rd_frame;
                                commit_addr <= addr;
                                commit_data <= {shift_in, mosi_q};
                                addr        <= (int'(addr) == ADDR_LAST) ? '0 : addr + 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        // A fall at bit 0 starts a fresh word; later falls shift.
                        if (sclk_fall && rd_frame) begin
                            if (bit_cnt == '0) begin
                                tx_sh <= rd_value;
                            end else begin
                                tx_sh <= {tx_sh[WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                    default: bit_cnt <= '0;
                endcase
            end
        end
    end

    // NOTE: the register bank is reset slot by slot because its reset value is architectural.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CFG; k++) cfg_q[k] <= CFG_RST_VAL;
            cfg_wr_pulse <= '0;
        end else begin
            cfg_wr_pulse <= '0;
            if (commit_pend && !commit_rd && ena) begin
                for (int k = 0; k < NUM_CFG; k++) begin
                    if (int'(commit_addr) == k) begin
                        cfg_q[k]        <= commit_data;
                        cfg_wr_pulse[k] <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg_out
        assign config_regs[k*WIDTH +: WIDTH] = cfg_q[k];
    end

    assign miso_oe         = (state == DATA) && rd_frame;
    assign spi.spi_miso_oe = miso_oe;
    assign spi.spi_miso    = miso_oe & tx_sh[WIDTH-1];

`ifdef SPI_REGBANK_IRQ_EN
    logic [WIDTH-1:0] prev_status [SHADOW_N];
    logic [WIDTH-1:0] pending     [SHADOW_N];

    // Clearing drops old pending bits only; a bit rising in the clear cycle survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SHADOW_N; s++) begin
                prev_status[s] <= '0;
                pending[s]     <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_STAT; s++) begin
                prev_status[s] <= status_regs[s*WIDTH +: WIDTH];
                if (commit_pend && commit_rd && int'(commit_addr) == NUM_CFG + s) begin
                    pending[s] <= status_regs[s*WIDTH +: WIDTH] & ~prev_status[s];
                end else begin
                    pending[s] <= pending[s] | (status_regs[s*WIDTH +: WIDTH] & ~prev_status[s]);
                end
            end
        end
    end

    always_comb begin
        irq = 1'b0;
        for (int s = 0; s < NUM_STAT; s++) irq = irq | (|pending[s]);
    end
`endif

endmodule

// File: tb/tb_spi_regbank.sv
// Self-checking bench for spi_regbank: SPI master tasks plus a frame-level reference model.
module tb_spi_regbank;

    localparam int         NUM_CFG  = 8;
    localparam int         NUM_STAT = 4;
    localparam int         WIDTH    = 8;
    localparam int         TOTAL    = NUM_CFG + NUM_STAT;
    localparam logic [7:0] RST_VAL  = 8'h5A;
    localparam int         HALF     = 8;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      ena = 1'b1;
    logic [NUM_CFG*WIDTH-1:0]  config_regs;
    logic [NUM_CFG-1:0]        cfg_wr_pulse;
    logic [NUM_STAT*WIDTH-1:0] status_regs = '0;
`ifdef SPI_REGBANK_IRQ_EN
    logic                      irq;
`endif

    spi_regbank_if sif ();

    spi_regbank #(
        .NUM_CFG     (NUM_CFG),
        .NUM_STAT    (NUM_STAT),
        .WIDTH       (WIDTH),
        .CFG_RST_VAL (RST_VAL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .spi          (sif),
        .config_regs  (config_regs),
        .cfg_wr_pulse (cfg_wr_pulse),
        .status_regs  (status_regs)
`ifdef SPI_REGBANK_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    int                 checks   = 0;
    int                 failures = 0;
    logic [7:0]         cfg_model [NUM_CFG];
    logic [7:0]         wr_words  [8];
    logic [7:0]         rd_words  [8];
    logic [7:0]         exp_words [8];
    logic [NUM_CFG-1:0] pulse_log  [$];
    logic [NUM_CFG-1:0] exp_pulses [$];
    logic               oe_seen;
    logic               stat_swap = 1'b0;
    logic [31:0]        stat_next = '0;

    always @(negedge clk) begin
        if (!rst && cfg_wr_pulse != '0) pulse_log.push_back(cfg_wr_pulse);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int next_addr(input int a);
        if (a == TOTAL - 1) return 0;
        return (a + 1) % 128;
    endfunction

    function automatic logic [7:0] model_read(input int a, input logic [31:0] snap);
        if (a < NUM_CFG) return cfg_model[a];
        if (a < TOTAL) return snap[(a - NUM_CFG)*8 +: 8];
        return 8'h00;
    endfunction

    // One SPI mode-0 bit per iteration: mosi set while sclk low, miso sampled just before the rise.
    task automatic spi_bits(input logic [31:0] tx, input int nbits, output logic [31:0] rx);
        rx = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            sif.spi_mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = sif.spi_miso;
            sif.spi_clk = 1'b1;
            repeat (HALF) @(negedge clk);
            sif.spi_clk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input int nwords, input int last_bits);
        logic [31:0] rx;
        oe_seen = 1'b0;
        sif.spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits({24'h0, cmd}, 8, rx);
        if (stat_swap) status_regs = stat_next;
        for (int w = 0; w < nwords; w++) begin
            spi_bits({24'h0, wr_words[w]}, WIDTH, rx);
            rd_words[w] = rx[7:0];
            if (w == 0) oe_seen = sif.spi_miso_oe;
        end
        if (last_bits > 0) spi_bits({24'h0, wr_words[nwords]} >> (WIDTH - last_bits), last_bits, rx);
        repeat (HALF) @(negedge clk);
        sif.spi_cs_n = 1'b1;
        repeat (2*HALF) @(negedge clk);
    endtask

    task automatic test_reset();
        sif.spi_cs_n = 1'b1;
        sif.spi_clk  = 1'b0;
        sif.spi_mosi = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NUM_CFG; k++) begin
            checks++;
            if (config_regs[k*WIDTH +: WIDTH] !== RST_VAL) begin
                failures++;
                $display("FAIL reset_cfg[%0d]: got %h expected %h", k, config_regs[k*WIDTH +: WIDTH], RST_VAL);
            end
            cfg_model[k] = RST_VAL;
        end
        checks++;
        if (cfg_wr_pulse !== '0) begin
            failures++;
            $display("FAIL reset_pulse: got %b expected 0", cfg_wr_pulse);
        end
        checks++;
        if (sif.spi_miso_oe !== 1'b0 || sif.spi_miso !== 1'b0) begin
            failures++;
            $display("FAIL reset_miso: got oe=%b miso=%b expected 0 0", sif.spi_miso_oe, sif.spi_miso);
        end
`ifdef SPI_REGBANK_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
`endif
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_write();
        pulse_log.delete();
        wr_words[0] = 8'hC3;
        spi_frame(8'h03, 1, 0);
        cfg_model[3] = 8'hC3;
        for (int k = 0; k < NUM_CFG; k++) begin
            checks++;
            if (config_regs[k*WIDTH +: WIDTH] !== cfg_model[k]) begin
                failures++;
                $display("FAIL single_write_cfg[%0d]: got %h expected %h", k, config_regs[k*WIDTH +: WIDTH], cfg_model[k]);
            end
        end
        checks++;
        if (pulse_log.size() != 1 || pulse_log[0] !== 8'b0000_1000) begin
            failures++;
            $display("FAIL single_write_pulse: got %0d strobe cycles first=%b expected 1 cycle of 00001000",
                     pulse_log.size(), (pulse_log.size() > 0) ? pulse_log[0] : 8'h00);
        end
    endtask

    task automatic test_burst_write();
        pulse_log.delete();
        wr_words[0] = 8'h11;
        wr_words[1] = 8'h22;
        wr_words[2] = 8'h33;
        wr_words[3] = 8'h44;
        spi_frame(8'h06, 4, 0);
        cfg_model[6] = 8'h11;
        cfg_model[7] = 8'h22;
        checks++;
        if (config_regs[6*WIDTH +: WIDTH] !== 8'h11 || config_regs[7*WIDTH +: WIDTH] !== 8'h22) begin
            failures++;
            $display("FAIL burst_write_cfg: got cfg6=%h cfg7=%h expected 11 22",
                     config_regs[6*WIDTH +: WIDTH], config_regs[7*WIDTH +: WIDTH]);
        end
        checks++;
        if (pulse_log.size() != 2 || pulse_log[0] !== 8'h40 || pulse_log[1] !== 8'h80) begin
            failures++;
            $display("FAIL burst_write_pulse: got %0d strobe cycles expected 2 (01000000 then 10000000)", pulse_log.size());
        end
        checks++;
        if (config_regs[0 +: 6*WIDTH] !== {cfg_model[5], cfg_model[4], cfg_model[3], cfg_model[2], cfg_model[1], cfg_model[0]}) begin
            failures++;
            $display("FAIL burst_write_others: got %h, other slots changed", config_regs[0 +: 6*WIDTH]);
        end
    endtask

    task automatic test_burst_read();
        pulse_log.delete();
        status_regs = 32'hD4C3_B2A1;
        stat_next   = 32'h1E2D_3C4B;
        stat_swap   = 1'b1;
        for (int w = 0; w < 3; w++) wr_words[w] = 8'h00;
        repeat (4) @(negedge clk);
        spi_frame(8'h8A, 3, 0);
        stat_swap = 1'b0;
        exp_words[0] = 8'hC3;
        exp_words[1] = 8'hD4;
        exp_words[2] = cfg_model[0];
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (rd_words[w] !== exp_words[w]) begin
                failures++;
                $display("FAIL burst_read_word%0d: got %h expected %h", w, rd_words[w], exp_words[w]);
            end
        end
        checks++;
        if (oe_seen !== 1'b1 || sif.spi_miso_oe !== 1'b0) begin
            failures++;
            $display("FAIL burst_read_oe: got in-frame=%b idle=%b expected 1 0", oe_seen, sif.spi_miso_oe);
        end
        checks++;
        if (pulse_log.size() != 0) begin
            failures++;
            $display("FAIL burst_read_pulse: got %0d strobe cycles expected 0", pulse_log.size());
        end
    endtask

    task automatic test_partial_word();
        pulse_log.delete();
        wr_words[0] = 8'hFF;
        spi_frame(8'h01, 0, 5);
        checks++;
        if (config_regs[1*WIDTH +: WIDTH] !== cfg_model[1] || pulse_log.size() != 0) begin
            failures++;
            $display("FAIL partial_word: got cfg1=%h strobes=%0d expected %h 0",
                     config_regs[1*WIDTH +: WIDTH], pulse_log.size(), cfg_model[1]);
        end
        wr_words[0] = 8'h96;
        spi_frame(8'h01, 1, 0);
        cfg_model[1] = 8'h96;
        checks++;
        if (config_regs[1*WIDTH +: WIDTH] !== 8'h96 || pulse_log.size() != 1 || pulse_log[0] !== 8'h02) begin
            failures++;
            $display("FAIL partial_recover: got cfg1=%h strobes=%0d expected 96 1", config_regs[1*WIDTH +: WIDTH], pulse_log.size());
        end
    endtask

    task automatic test_ena_low();
        pulse_log.delete();
        ena = 1'b0;
        wr_words[0] = 8'hE7;
        spi_frame(8'h00, 1, 0);
        ena = 1'b1;
        checks++;
        if (config_regs[0 +: WIDTH] !== cfg_model[0] || pulse_log.size() != 0) begin
            failures++;
            $display("FAIL ena_low: got cfg0=%h strobes=%0d expected %h 0", config_regs[0 +: WIDTH], pulse_log.size(), cfg_model[0]);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 14; f++) begin
            logic               rd;
            int                 start;
            int                 n;
            int                 a;
            logic [31:0]        snap;
            logic [NUM_CFG-1:0] one_hot;
            rd          = 1'($urandom_range(0, 1));
            start       = $urandom_range(0, TOTAL + 1);
            n           = $urandom_range(1, 4);
            ena         = ($urandom_range(0, 3) != 0);
            status_regs = $urandom;
            snap        = status_regs;
            stat_swap   = 1'($urandom_range(0, 1));
            stat_next   = $urandom;
            for (int w = 0; w < n; w++) wr_words[w] = 8'($urandom);
            exp_pulses.delete();
            a = start;
            for (int w = 0; w < n; w++) begin
                if (rd) begin
                    exp_words[w] = model_read(a, snap);
                end else if (ena && a < NUM_CFG) begin
                    cfg_model[a] = wr_words[w];
                    one_hot      = '0;
                    one_hot[a]   = 1'b1;
                    exp_pulses.push_back(one_hot);
                end
                a = next_addr(a);
            end
            repeat (4) @(negedge clk);
            pulse_log.delete();
            spi_frame({rd, 7'(start)}, n, 0);
            stat_swap = 1'b0;
            ena       = 1'b1;
            if (rd) begin
                for (int w = 0; w < n; w++) begin
                    checks++;
                    if (rd_words[w] !== exp_words[w]) begin
                        failures++;
                        $display("FAIL rand%0d_read_word%0d addr=%0d: got %h expected %h", f, w, start, rd_words[w], exp_words[w]);
                    end
                end
            end
            checks++;
            if (pulse_log.size() != exp_pulses.size()) begin
                failures++;
                $display("FAIL rand%0d_pulse_count: got %0d expected %0d", f, pulse_log.size(), exp_pulses.size());
            end else begin
                for (int i = 0; i < exp_pulses.size(); i++) begin
                    checks++;
                    if (pulse_log[i] !== exp_pulses[i]) begin
                        failures++;
                        $display("FAIL rand%0d_pulse%0d: got %b expected %b", f, i, pulse_log[i], exp_pulses[i]);
                    end
                end
            end
            for (int k = 0; k < NUM_CFG; k++) begin
                checks++;
                if (config_regs[k*WIDTH +: WIDTH] !== cfg_model[k]) begin
                    failures++;
                    $display("FAIL rand%0d_cfg[%0d]: got %h expected %h", f, k, config_regs[k*WIDTH +: WIDTH], cfg_model[k]);
                end
            end
        end
    endtask

`ifdef SPI_REGBANK_IRQ_EN
    task automatic test_irq();
        status_regs = '0;
        repeat (4) @(negedge clk);
        for (int w = 0; w < NUM_STAT; w++) wr_words[w] = 8'h00;
        spi_frame(8'h80 | 8'(NUM_CFG), NUM_STAT, 0);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_cleared: got %b expected 0", irq);
        end
        status_regs[1*WIDTH] = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_raise: got %b expected 1", irq);
        end
        spi_frame(8'h80 | 8'(NUM_CFG + 1), 1, 0);
        checks++;
        if (irq !== 1'b0 || rd_words[0] !== 8'h01) begin
            failures++;
            $display("FAIL irq_read_clear: got irq=%b data=%h expected 0 01", irq, rd_words[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_burst_write();
        test_burst_read();
        test_partial_word();
        test_ena_low();
        test_random();
`ifdef SPI_REGBANK_IRQ_EN
        test_irq();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_regbank.md
Name: spi_regbank

Overview:
- Parametrised successor to the fixed 8x8 SPI register wrapper.
- Contains its own oversampled SPI mode-0 slave and separately sized config (RW) and status (RO) banks.
- Supports burst transfers with auto-incrementing address, per-register write strobes, and a coherent status snapshot per transaction.
- Sits between the chip pins and the user core, which consumes config_regs and supplies status_regs.

Parameters:
- NUM_CFG, 8, number of RW config registers (1..120)
- NUM_STAT, 4, number of RO status registers (0..8); NUM_CFG+NUM_STAT <= 128
- WIDTH, 8, register and data-word width in bits (8..32)
- CFG_RST_VAL, 0, reset value of every config register (WIDTH bits)

Ports:
- clk  in  1  system clock; must be >= 8x spi_clk frequency
- rst  in  1  asynchronous, active-high reset
- ena  in  1  write enable; when low, SPI writes are ignored but reads still work
- spi_cs_n  in  1  chip select, active low
- spi_clk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
- spi_mosi  in  1  serial data in, MSB first
- spi_miso  out  1  serial data out, MSB first
- spi_miso_oe  out  1  high while a read data phase is active
- config_regs  out  NUM_CFG*WIDTH  flat config bank; register k occupies bits [k*WIDTH +: WIDTH]
- cfg_wr_pulse  out  NUM_CFG  one-clk strobe per config register on commit
- status_regs  in  NUM_STAT*WIDTH  flat status inputs, same packing as config_regs
- irq  out  1  present only when SPI_REGBANK_IRQ_EN is defined

Behaviour:
- Reset (async, rst=1):
  - config_regs = CFG_RST_VAL in every slot.
  - cfg_wr_pulse, spi_miso, spi_miso_oe, irq = 0.
  - FSM = IDLE; all synchronisers cleared.
- Synchronisation and edge detection:
  - spi_cs_n, spi_clk, spi_mosi each pass through a 2-FF synchroniser.
  - Rising/falling sclk edges are detected from the synchronised value.
  - mosi is sampled on the rise-detect cycle.
- Frame format:
  - Command word is 8 bits: bit7 = 1 read / 0 write; bits[6:0] = start address.
  - Command is followed by N data words of WIDTH bits each.
- Address map:
  - 0..NUM_CFG-1 = config registers.
  - NUM_CFG..NUM_CFG+NUM_STAT-1 = status registers.
  - Any other address reads 0; writes to it are dropped with no strobe.
- FSM:
  - IDLE -> CMD on synchronised cs_n falling.
  - CMD -> DATA after the 8th rise; address latched, status_regs snapshotted into a shadow bank in the same cycle.
  - DATA loops word by word until cs_n rises.
  - Any state -> IDLE on cs_n rising (highest priority).
- Write commit:
  - On the clk after the WIDTH-th rise of a data word, if ena=1 and the address is a config address: update config_regs[addr] and pulse cfg_wr_pulse[addr] for exactly 1 clk.
  - Writes to status addresses are ignored.
  - A partial word at cs_n rising is discarded; no commit and no strobe.
- Read path:
  - TX shift register loads shadow/config[addr] on the first sclk fall after the command or previous word completes.
  - spi_miso shifts on each subsequent sclk fall.
  - spi_miso_oe = 1 in DATA of a read frame; spi_miso = 0 otherwise.
  - Config values come from live registers. Status values come only from the snapshot, so a burst is coherent.
- Address increment:
  - After each data word, addr <= addr+1.
  - Wrap to 0 when addr = NUM_CFG+NUM_STAT-1.
- Write-after-read in the same burst does not exist: one direction per frame.
- cs_n deassertion mid-word or reset mid-frame: FSM returns to IDLE, shift counters clear, and no partial state is committed.

Optional Feature:
- Macro SPI_REGBANK_IRQ_EN.
- Defined:
  - irq port exists; per status register a pending mask = pending | (status_regs & ~prev_status), with prev_status sampled every clk.
  - irq = OR of all pending bits.
  - Completing a read word from status register s clears pending[s] on the commit cycle. A new rising bit in that same cycle wins and stays set.
  - Reset clears pending.
- Undefined: no irq port, no pending logic.

Decomposition:
- Package spi_regbank_pkg:
  - typedef spi_state_e {IDLE, CMD, DATA}
  - localparam CMD_W = 8, RD_BIT = 7
  - function for the address-wrap limit
- Sub-module spi_sync_edge: 2-FF synchroniser plus rise/fall detect. Instantiate it for sclk and cs_n; use the synchroniser only for mosi.

Test Plan:
- Reset, NUM_CFG=8, WIDTH=8, CFG_RST_VAL=8'h5A -> all config slots = 8'h5A; cfg_wr_pulse = 0; spi_miso_oe = 0.
- Single write 0x03, data 0xC3, ena=1 -> config[3] = 0xC3; cfg_wr_pulse = 8'b0000_1000 for 1 clk; other slots unchanged.
- Burst write from 0x06 with 4 words 0x11,0x22,0x33,0x44 (NUM_CFG=8, NUM_STAT=4):
  - config[6]=0x11, config[7]=0x22.
  - Words to status addresses 8,9 are dropped, no strobe.
- Burst read from 0x0A with 3 words (total 12 regs); status_regs changes after the command byte -> MISO returns snapshot stat[2], stat[3], then config[0] (wrap).
- cs_n raised after 5 bits of a write data word to 0x01 -> config[1] unchanged, no strobe; the next frame decodes correctly.
- IRQ_EN: status[1] bit0 rises 0->1 -> irq=1; read of address NUM_CFG+1 -> irq=0 after the word; ena=0 write to 0x00 -> no change, no strobe.
